hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 117 +++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Decode-stage hazard tracker for an in-order pipeline. Keeps a small
//   countdown per architectural register giving the cycles until its pending
//   result becomes forwardable, stalls Decode on a read of a busy register,
//   and resolves branch mispredicts in Execute into flush/redirect selects.
//   Also counts stall and flush cycles for performance statistics.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   dec_valid/rs1/rs2/*_used       Decode instruction and its source reads
//   dec_wb/dec_rd/dec_lat          Decode destination and result latency
//   freeze                         global hold: counters and stats frozen
//   branch_E/pred_E/actual_E/hit_E Execute branch resolution
//   stat_clr                       synchronous clear of the statistics
//   stall, pcwrite, ifid_write     Decode hazard stall and its write enables
//   flush, sel_target, sel_pcplus1 mispredict kill and redirect selects
//   stall_count, flush_count       saturating statistics counters
module hazard_scoreboard #(
    parameter int REG_AW = 5,
    parameter int LAT_W  = 3,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dec_valid,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic              dec_rs1_used,
    input  logic              dec_rs2_used,
    input  logic              dec_wb,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic [LAT_W-1:0]  dec_lat,
    input  logic              freeze,
    input  logic              branch_E,
    input  logic              pred_E,
    input  logic              actual_E,
    input  logic              hit_E,
    input  logic              stat_clr,
    output logic              stall,
    output logic              pcwrite,
    output logic              ifid_write,
    output logic              flush,
    output logic              sel_target,
    output logic              sel_pcplus1,
    output logic [STAT_W-1:0] stall_count,
    output logic [STAT_W-1:0] flush_count
);
    localparam int NREGS = 2**REG_AW;

    logic [LAT_W-1:0]  r_cnt [NREGS];
    logic [LAT_W-1:0]  w_dec [NREGS];
    logic [LAT_W-1:0]  w_nxt [NREGS];
    logic [STAT_W-1:0] r_stall_count;
    logic [STAT_W-1:0] r_flush_count;
    logic              w_rs1_busy;
    logic              w_rs2_busy;
    logic              w_mispredict;
    logic              w_issue;

    // r0 is hardwired zero, so reads of it never wait.
    assign w_rs1_busy = dec_rs1_used && (dec_rs1 != '0) && (r_cnt[dec_rs1] != '0);
    assign w_rs2_busy = dec_rs2_used && (dec_rs2 != '0) && (r_cnt[dec_rs2] != '0);
    assign stall      = dec_valid && (w_rs1_busy || w_rs2_busy);

    // A BTB miss implies predicted not-taken, so only a taken outcome is wrong.
    assign w_mispredict = branch_E && ((hit_E && (pred_E != actual_E)) || (!hit_E && actual_E));
    assign flush        = w_mispredict;
    assign sel_target   = branch_E && actual_E && (!pred_E || !hit_E);
    assign sel_pcplus1  = branch_E && hit_E && pred_E && !actual_E;

    assign pcwrite    = !(stall || freeze);
    assign ifid_write = !(stall || freeze);

    // Flush outranks everything: a killed Decode slot never claims its rd.
    assign w_issue = dec_valid && dec_wb && (dec_rd != '0) && !stall && !freeze && !flush;

    // Next countdown per register: saturating decrement, and on issue the
    // larger of the new latency and what is still pending (WAW never shortens).
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            w_dec[i] = (r_cnt[i] == '0) ? '0 : r_cnt[i] - LAT_W'(1);
            w_nxt[i] = w_dec[i];
            if (w_issue && (dec_rd == REG_AW'(i)) && (dec_lat > w_dec[i]))
                w_nxt[i] = dec_lat;
        end
        w_nxt[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                r_cnt[i] <= '0;
        end else if (!freeze) begin
            for (int i = 0; i < NREGS; i++)
                r_cnt[i] <= w_nxt[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else if (stat_clr) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else if (!freeze) begin
            if (stall && (r_stall_count != '1))
                r_stall_count <= r_stall_count + STAT_W'(1);
            if (flush && (r_flush_count != '1))
                r_flush_count <= r_flush_count + STAT_W'(1);
        end
    end

    assign stall_count = r_stall_count;
    assign flush_count = r_flush_count;

endmodule
